// File: rtl/pipe_stage_reg_if.sv
// Valid/ready channel carrying one register-writeback bundle plus sideband.
// The master drives the payload and valid; the slave drives ready.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SIDE_W = 8
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] waddr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [SIDE_W-1:0] side;

  modport master (output valid, waddr, we, wdata, side, input  ready);
  modport slave  (input  valid, waddr, we, wdata, side, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer. Empty slots hold an all-zero NOP bubble.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SIDE_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pipe_stage_reg_if.slave        in_if,
  pipe_stage_reg_if.master       out_if,
  output logic [1:0]             occupancy
);

  localparam int unsigned ENT_W = ADDR_W + 1 + DATA_W + SIDE_W;

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] main_q;
  logic             main_valid_q;
  logic [1:0]       occ_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_ent   = {in_if.waddr, in_if.we, in_if.wdata, in_if.side};
  assign in_xfer  = in_if.valid & in_if.ready;
  assign out_xfer = main_valid_q & out_if.ready;

  // main_q is zeroed whenever it empties, so out_* stays a pure register and bubbles read 0
  assign out_if.valid = main_valid_q;
  assign {out_if.waddr, out_if.we, out_if.wdata, out_if.side} = main_q;
  assign occupancy = occ_q;

  if (SKID == 0) begin : g_single
    logic [ENT_W-1:0] main_d;
    logic             main_valid_d;

    assign in_if.ready = ~main_valid_q | out_if.ready;

    always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      if (flush) begin
        main_d       = '0;
        main_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_d       = in_ent;
        main_valid_d = 1'b1;
      end else if (out_xfer) begin
        main_d       = '0;
        main_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        main_q       <= '0;
        main_valid_q <= 1'b0;
        occ_q        <= 2'd0;
      end else begin
        main_q       <= main_d;
        main_valid_q <= main_valid_d;
        occ_q        <= {1'b0, main_valid_d};
      end
    end
  end else begin : g_skid
    logic [ENT_W-1:0] main_d;
    logic             main_valid_d;
    logic [ENT_W-1:0] skid_q;
    logic [ENT_W-1:0] skid_d;
    logic             skid_valid_q;
    logic             skid_valid_d;

    // Depends only on a flop: no combinational path from out_ready to in_ready
    assign in_if.ready = ~skid_valid_q;

    always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
        main_d       = '0;
        main_valid_d = 1'b0;
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
        // Full: inputs are not accepted, only a drain can move data
        if (out_xfer) begin
          main_d       = skid_q;
          skid_d       = '0;
          skid_valid_d = 1'b0;
        end
      end else if (in_xfer) begin
        if (!main_valid_q || out_xfer) begin
          main_d       = in_ent;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = in_ent;
          skid_valid_d = 1'b1;
        end
      end else if (out_xfer) begin
        main_d       = '0;
        main_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        main_q       <= '0;
        main_valid_q <= 1'b0;
        skid_q       <= '0;
        skid_valid_q <= 1'b0;
        occ_q        <= 2'd0;
      end else begin
        main_q       <= main_d;
        main_valid_q <= main_valid_d;
        skid_q       <= skid_d;
        skid_valid_q <= skid_valid_d;
        occ_q        <= 2'(main_valid_d) + 2'(skid_valid_d);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances, directed vectors plus
// a random phase, checked by a per-instance scoreboard and an output monitor.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic [7:0]  side;
  } ent_t;

  localparam int unsigned ENT_W = $bits(ent_t);

  logic       clk = 1'b0;
  logic       rst;
  logic       flush     [2];
  logic       in_valid  [2];
  logic       out_ready [2];
  ent_t       in_e      [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  ent_t       out_e     [2];
  logic [1:0] occ       [2];

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_stage_reg_if #(.DATA_W(32), .ADDR_W(5), .SIDE_W(8)) u_in  ();
    pipe_stage_reg_if #(.DATA_W(32), .ADDR_W(5), .SIDE_W(8)) u_out ();

    assign u_in.valid   = in_valid[g];
    assign u_in.waddr   = in_e[g].waddr;
    assign u_in.we      = in_e[g].we;
    assign u_in.wdata   = in_e[g].wdata;
    assign u_in.side    = in_e[g].side;
    assign in_ready[g]  = u_in.ready;
    assign u_out.ready  = out_ready[g];
    assign out_valid[g] = u_out.valid;
    assign out_e[g]     = {u_out.waddr, u_out.we, u_out.wdata, u_out.side};

    pipe_stage_reg #(.DATA_W(32), .ADDR_W(5), .SIDE_W(8), .SKID(g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[g]),
      .in_if     (u_in.slave),
      .out_if    (u_out.master),
      .occupancy (occ[g])
    );
  end

  ent_t sb0[$];
  ent_t sb1[$];

  function automatic void sb_push(input int d, input ent_t e);
    if (d == 0) sb0.push_back(e); else sb1.push_back(e);
  endfunction

  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic void sb_clear(input int d);
    if (d == 0) sb0.delete(); else sb1.delete();
  endfunction

  function automatic ent_t sb_pop(input int d);
    return (d == 0) ? sb0.pop_front() : sb1.pop_front();
  endfunction

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL skid%0d %s: got 0x%0h expected 0x%0h (t=%0t)", d, nm, act, exp, $time);
    end
  endtask

  // Monitor: pops on every out-xfer, checks bubbles and stall stability
  logic stall_q [2];
  ent_t stall_e [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        stall_q[d] <= 1'b0;
      end else begin
        if (out_valid[d] && stall_q[d])
          chk(d, "stall_stable", 64'(out_e[d]), 64'(stall_e[d]));
        if (out_valid[d] && out_ready[d]) begin
          chk(d, "sb_nonempty", 64'(sb_size(d) != 0), 64'd1);
          if (sb_size(d) != 0) chk(d, "sb_data", 64'(out_e[d]), 64'(sb_pop(d)));
        end else if (!out_valid[d]) begin
          chk(d, "bubble_zero", 64'(out_e[d]), 64'd0);
        end
        stall_q[d] <= out_valid[d] & ~out_ready[d] & ~flush[d];
        stall_e[d] <= out_e[d];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the entry on the input until accepted; records it on acceptance
  task automatic send(input int d, input ent_t e);
    bit acc = 1'b0;
    in_valid[d] = 1'b1;
    in_e[d]     = e;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready[d] && !flush[d] && !rst;
      tick();
      if (acc) sb_push(d, e);
    end
    if (!acc) chk(d, "send_timeout", 64'd0, 64'd1);
    in_valid[d] = 1'b0;
  endtask

  task automatic run_dir(input int d);
    int unsigned t0;
    // Reset held two cycles with a valid input present
    rst = 1'b1;
    in_valid[d] = 1'b1;
    in_e[d] = '{5'd9, 1'b1, 32'h1234_5678, 8'h77};
    repeat (2) begin
      @(negedge clk);
      chk(d, "rst_valid", 64'(out_valid[d]), 64'd0);
      chk(d, "rst_we", 64'(out_e[d].we), 64'd0);
      chk(d, "rst_payload", 64'(out_e[d]), 64'd0);
      chk(d, "rst_occ", 64'(occ[d]), 64'd0);
    end
    tick();
    rst = 1'b0;
    in_valid[d] = 1'b0;
    sb_clear(0);
    sb_clear(1);
    @(negedge clk);
    chk(d, "rst_in_ready", 64'(in_ready[d]), 64'd1);
    tick();

    // Single entry, then a 16-deep back-to-back stream
    out_ready[d] = 1'b1;
    send(d, '{5'd5, 1'b1, 32'hDEAD_BEEF, 8'h3C});
    @(negedge clk);
    chk(d, "lat_valid", 64'(out_valid[d]), 64'd1);
    chk(d, "lat_payload", 64'(out_e[d]), 64'({5'd5, 1'b1, 32'hDEAD_BEEF, 8'h3C}));
    tick();
    t0 = cyc_cnt;
    for (int i = 0; i < 16; i++)
      send(d, '{5'(i), i[0], 32'h1000_0000 + 32'(i), 8'(i * 3)});
    chk(d, "stream_cycles", 64'(cyc_cnt - t0), 64'd16);
    repeat (3) tick();

    // Backpressure
    out_ready[d] = 1'b0;
    send(d, '{5'd1, 1'b1, 32'h11, 8'h01});
    if (d == 1) begin
      send(d, '{5'd2, 1'b1, 32'h22, 8'h02});
      @(negedge clk);
      chk(d, "full_occ", 64'(occ[d]), 64'd2);
    end else begin
      @(negedge clk);
      chk(d, "full_occ", 64'(occ[d]), 64'd1);
    end
    chk(d, "full_in_ready", 64'(in_ready[d]), 64'd0);
    chk(d, "full_head", 64'(out_e[d].wdata), 64'h11);
    repeat (3) tick();
    out_ready[d] = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk(d, "drain_occ", 64'(occ[d]), 64'd0);
    tick();

    // Flush while full with a simultaneous input
    out_ready[d] = 1'b0;
    send(d, '{5'd3, 1'b1, 32'h55, 8'h05});
    if (d == 1) send(d, '{5'd4, 1'b1, 32'h66, 8'h06});
    flush[d]    = 1'b1;
    in_valid[d] = 1'b1;
    in_e[d]     = '{5'd6, 1'b1, 32'h33, 8'h03};
    tick();
    sb_clear(d);
    flush[d]    = 1'b0;
    in_valid[d] = 1'b0;
    @(negedge clk);
    chk(d, "flush_valid", 64'(out_valid[d]), 64'd0);
    chk(d, "flush_we", 64'(out_e[d].we), 64'd0);
    chk(d, "flush_occ", 64'(occ[d]), 64'd0);
    chk(d, "flush_in_ready", 64'(in_ready[d]), 64'd1);
    tick();
    out_ready[d] = 1'b1;
    repeat (4) tick();

    // Bubble after a single write
    send(d, '{5'd7, 1'b1, 32'hA5A5_A5A5, 8'hFF});
    tick();
    @(negedge clk);
    chk(d, "bubble_valid", 64'(out_valid[d]), 64'd0);
    chk(d, "bubble_we", 64'(out_e[d].we), 64'd0);
    chk(d, "bubble_waddr", 64'(out_e[d].waddr), 64'd0);
    chk(d, "bubble_wdata", 64'(out_e[d].wdata), 64'd0);
    tick();

    // Reset mid-operation discards held entries
    out_ready[d] = 1'b0;
    send(d, '{5'd8, 1'b1, 32'h77, 8'h08});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_clear(0);
    sb_clear(1);
    @(negedge clk);
    chk(d, "midrst_occ", 64'(occ[d]), 64'd0);
    chk(d, "midrst_valid", 64'(out_valid[d]), 64'd0);
    tick();
  endtask

  task automatic run_rand(input int d, input int n);
    bit   acc = 1'b0;
    bit   fl  = 1'b0;
    logic rb;
    logic nr;
    ent_t cur;
    for (int i = 0; i < n; i++) begin
      tick();
      if (fl) sb_clear(d);
      else if (acc) sb_push(d, cur);
      nr = ($urandom_range(0, 2) != 0);
      if (d == 1 && nr != out_ready[d]) begin
        rb = in_ready[d];
        out_ready[d] = nr;
        #1;
        chk(d, "ready_no_comb", 64'(in_ready[d]), 64'(rb));
      end else begin
        out_ready[d] = nr;
      end
      cur         = ENT_W'({$urandom(), $urandom()});
      in_e[d]     = cur;
      in_valid[d] = ($urandom_range(0, 2) != 0);
      flush[d]    = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      acc = in_valid[d] & in_ready[d];
      fl  = flush[d];
    end
    tick();
    if (fl) sb_clear(d);
    else if (acc) sb_push(d, cur);
    in_valid[d]  = 1'b0;
    flush[d]     = 1'b0;
    out_ready[d] = 1'b1;
    repeat (5) tick();
    chk(d, "rand_drained", 64'(sb_size(d)), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      flush[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      in_e[d]      = '0;
    end
    for (int d = 0; d < 2; d++) begin
      run_dir(d);
      run_rand(d, 5000);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
